// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling, stop-bit check.
// One byte per good frame on data_o/rxvalid_o, or a frameerr_o pulse for a bad stop bit.
module uart_rx #(
  parameter int p_clockFreq = 100_000_000,
  parameter int p_baudRate  = 115_200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       rxvalid_o,
  output logic       frameerr_o
);

  localparam int c_periodTimer = p_clockFreq / p_baudRate;
  localparam int c_halfPeriod  = c_periodTimer / 2;
  localparam logic [15:0] c_periodLast = 16'(c_periodTimer - 1);
  localparam logic [15:0] c_halfLast   = 16'(c_halfPeriod - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  logic        rx_meta;
  logic        rx_s;
  logic [2:0]  state;
  logic [15:0] timer;
  logic [2:0]  bitcnt;
  logic [7:0]  shift;

  // Synchroniser presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= S_IDLE;
      timer      <= '0;
      bitcnt     <= '0;
      shift      <= '0;
      data_o     <= '0;
      rxvalid_o  <= 1'b0;
      frameerr_o <= 1'b0;
    end else begin
      rx_meta    <= rx_i;
      rx_s       <= rx_meta;
      rxvalid_o  <= 1'b0;
      frameerr_o <= 1'b0;

      case (state)
        S_IDLE: begin
          timer <= '0;
          if (!rx_s) state <= S_START;
        end

        // Re-check the start bit at its middle; a short low pulse is a glitch.
        S_START: begin
          if (timer == c_halfLast) begin
            timer <= '0;
            if (!rx_s) begin
              state  <= S_DATA;
              bitcnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end

        S_DATA: begin
          if (timer == c_periodLast) begin
            timer         <= '0;
            shift[bitcnt] <= rx_s;
            bitcnt        <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= S_STOP;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
        S_STOP: begin
          if (timer == c_periodLast) begin
            timer <= '0;
            if (rx_s) begin
              data_o    <= shift;
              rxvalid_o <= 1'b1;
              state     <= S_IDLE;
            end else begin
              frameerr_o <= 1'b1;
              state      <= S_RECOVER;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end

        S_RECOVER: begin
          timer <= '0;
          if (rx_s) state <= S_IDLE;
        end

        default: begin
          timer <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
